// File: rtl/zion_rsp_skid_stage.sv
// Registered valid/ready stage with a 2-entry skid buffer for response paths.
// iRdy is registered, so no combinational path runs from oRdy back to iRdy.
//
//   state | meaning
//   ------+------------------------------
//   EMPTY | no entries held
//   BUSY  | one entry, in main
//   FULL  | two entries, main (head) + skid
module zion_rsp_skid_stage #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             iVld,
  output logic             iRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             oRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [1:0]       oCnt
);

  if (WIDTH < 1) begin : g_width_chk
`ifdef CHECK_ERR_EXIT
    $fatal(1, "zion_rsp_skid_stage: WIDTH must be >= 1");
`else
    $error("zion_rsp_skid_stage: WIDTH must be >= 1");
`endif
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, next_state;
  logic             acc, rel;
  logic             main_we, main_from_skid, skid_we;
  logic [WIDTH-1:0] main_q, skid_q;

  assign acc  = iVld & iRdy;
  assign rel  = oVld & oRdy;
  assign oDat = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      iRdy  <= 1'b1;
    end else begin
      state <= next_state;
      iRdy  <= (next_state != FULL);
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) next_state = BUSY;
        BUSY: begin
          if (acc && !rel)      next_state = FULL;
          else if (!acc && rel) next_state = EMPTY;
        end
        FULL:    if (rel) next_state = BUSY;
        default: next_state = EMPTY;
      endcase
    end
  end

  // Flush suppresses every data write so a same-cycle beat is discarded.
  always_comb begin
    oVld           = (state != EMPTY);
    oCnt           = state;
    main_we        = 1'b0;
    main_from_skid = 1'b0;
    skid_we        = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY: main_we = acc;
        BUSY: begin
          main_we = acc & rel;
          skid_we = acc & ~rel;
        end
        FULL: begin
          main_we        = rel;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= INI_DATA;
      skid_q <= INI_DATA;
    end else begin
      if (main_we) main_q <= main_from_skid ? skid_q : iDat;
      if (skid_we) skid_q <= iDat;
    end
  end

endmodule

// File: tb/tb_zion_rsp_skid_stage.sv
// Bench for zion_rsp_skid_stage: directed vector table, then a random run
// checked against a queue model of the stage.
module tb_zion_rsp_skid_stage;

  logic       clk = 1'b0;
  logic       rst, flush, ivld, irdy, ovld, ordy;
  logic [7:0] idat, odat;
  logic [1:0] ocnt;

  int n_tests = 0;
  int n_fail  = 0;

  zion_rsp_skid_stage #(.WIDTH(8), .INI_DATA(8'hA5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iVld(ivld), .iRdy(irdy), .iDat(idat),
    .oVld(ovld), .oRdy(ordy), .oDat(odat), .oCnt(ocnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, flush, ivld;
    logic [7:0] idat;
    logic       ordy;
    logic       evld, erdy;
    logic [1:0] ecnt;
    logic       chkd;
    logic [7:0] edat;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, f, v, input logic [7:0] d, input logic o,
                     input logic ev, er, input logic [1:0] ec,
                     input logic cd, input logic [7:0] ed, input string nm);
    vec_t t;
    t = '{r, f, v, d, o, ev, er, ec, cd, ed, nm};
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int unsigned q[$];
  bit          m_rdy;
  bit          a, r;
  int          beats, cyc;

  initial begin
    rst = 1'b1; flush = 1'b0; ivld = 1'b0; idat = 8'h00; ordy = 1'b0;

    //   rst f  v  idat  ordy  vld rdy cnt chk dat
    add(1, 0, 0, 8'h00, 0,    0, 1, 0, 1, 8'hA5, "reset0");
    add(1, 0, 0, 8'h00, 0,    0, 1, 0, 1, 8'hA5, "reset1");
    for (int i = 1; i <= 8; i++)
      add(0, 0, 1, 8'(i), 1,  1, 1, 1, 1, 8'(i), "stream");
    add(0, 0, 0, 8'h00, 1,    0, 1, 0, 1, 8'h08, "stream_drain");
    add(0, 0, 1, 8'h11, 0,    1, 1, 1, 1, 8'h11, "bp_first");
    add(0, 0, 1, 8'h22, 0,    1, 0, 2, 1, 8'h11, "bp_full");
    add(0, 0, 1, 8'h99, 0,    1, 0, 2, 1, 8'h11, "bp_hold");
    add(0, 0, 0, 8'h00, 1,    1, 1, 1, 1, 8'h22, "bp_rel1");
    add(0, 0, 0, 8'h00, 1,    0, 1, 0, 1, 8'h22, "bp_rel2");
    add(0, 0, 1, 8'h33, 0,    1, 1, 1, 1, 8'h33, "accrel_load");
    add(0, 0, 1, 8'h44, 1,    1, 1, 1, 1, 8'h44, "accrel");
    add(0, 0, 1, 8'h66, 0,    1, 0, 2, 1, 8'h44, "flush_fill");
    add(0, 1, 1, 8'h55, 1,    0, 1, 0, 1, 8'h44, "flush");
    add(0, 0, 0, 8'h00, 1,    0, 1, 0, 1, 8'h44, "flush_after");
    add(0, 0, 1, 8'h77, 0,    1, 1, 1, 1, 8'h77, "rstfl_fill1");
    add(0, 0, 1, 8'h88, 0,    1, 0, 2, 1, 8'h77, "rstfl_fill2");
    add(1, 1, 1, 8'h12, 1,    0, 1, 0, 1, 8'hA5, "rst_flush");

    foreach (vecs[k]) begin
      rst = vecs[k].rst; flush = vecs[k].flush; ivld = vecs[k].ivld;
      idat = vecs[k].idat; ordy = vecs[k].ordy;
      @(posedge clk); #1;
      chk({vecs[k].name, ".oVld"}, ovld, vecs[k].evld);
      chk({vecs[k].name, ".iRdy"}, irdy, vecs[k].erdy);
      chk({vecs[k].name, ".oCnt"}, ocnt, vecs[k].ecnt);
      if (vecs[k].chkd) chk({vecs[k].name, ".oDat"}, odat, vecs[k].edat);
    end
    chk("rst_flush.skid", dut.skid_q, 8'hA5);

    // Random run: queue model, iRdy is "fewer than two held after the edge".
    q.delete();
    m_rdy = 1'b1;
    beats = 0;
    cyc   = 0;
    rst   = 1'b0;
    while (beats < 10000 && cyc < 60000) begin
      ivld  = ($urandom_range(0, 99) < 70);
      idat  = 8'($urandom);
      ordy  = ($urandom_range(0, 99) < 65);
      flush = ($urandom_range(0, 499) == 0);
      if (flush) begin
        q.delete();
        m_rdy = 1'b1;
      end else begin
        a = ivld & m_rdy;
        r = (q.size() > 0) & ordy;
        if (r) void'(q.pop_front());
        if (a) begin
          q.push_back(idat);
          beats++;
        end
        m_rdy = (q.size() < 2);
      end
      @(posedge clk); #1;
      cyc++;
      chk("rand.oVld", ovld, (q.size() > 0));
      chk("rand.iRdy", irdy, m_rdy);
      chk("rand.oCnt", ocnt, q.size());
      if (q.size() > 0) chk("rand.oDat", odat, q[0]);
    end
    n_tests++;
    if (beats < 10000) begin
      n_fail++;
      $display("FAIL rand.timeout: beats %0d expected 10000", beats);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
